// File: rtl/doc5503_host_access.sv
// -----------------------------------------------------------------------------
// doc5503_host_access
//
// Host-side access sequencer for the DOC 5503 register file. Accepts single
// byte read/write transactions over a ready/valid handshake, splits the host
// address into a register group and an oscillator index, fires a one-cycle
// request pulse at the matching per-group priority RAM port, waits a fixed
// service window, then returns read data to the host.
//
// Parameters:
//   NUM_GROUPS   RAM-backed register groups (address groups >= this are unmapped)
//   ADDR_WIDTH   oscillator index width; host address is ADDR_WIDTH+3 bits
//   DATA_WIDTH   register data width
//   WAIT_CYCLES  service window in cycles, 2..15; must cover the worst-case
//                latency of the slowest priority port
//
// Ports:
//   clk_i, reset_i          rising-edge clock, asynchronous active-high reset
//   host_req_i/host_we_i    transaction request and direction (1 = write)
//   host_addr_i             {group[2:0], oscillator[ADDR_WIDTH-1:0]}
//   host_wdata_i            write data
//   host_ready_o            high only while idle; accept = req && ready
//   host_rvalid_o           one-cycle read-response strobe
//   host_rdata_o            read data, held until the next read response
//   wr_req_o / rd_req_o     one-cycle request pulse, one bit per group
//   wr_addr_o, wr_data_o    shared write oscillator index and data
//   rd_addr_o               shared read oscillator index
//   rd_data_i               per-group priority read data
// -----------------------------------------------------------------------------
module doc5503_host_access #(
  parameter int NUM_GROUPS  = 7,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 host_req_i,
  input  logic                                 host_we_i,
  input  logic [ADDR_WIDTH+2:0]                host_addr_i,
  input  logic [DATA_WIDTH-1:0]                host_wdata_i,
  output logic                                 host_ready_o,
  output logic                                 host_rvalid_o,
  output logic [DATA_WIDTH-1:0]                host_rdata_o,
  output logic [NUM_GROUPS-1:0]                wr_req_o,
  output logic [ADDR_WIDTH-1:0]                wr_addr_o,
  output logic [DATA_WIDTH-1:0]                wr_data_o,
  output logic [NUM_GROUPS-1:0]                rd_req_o,
  output logic [ADDR_WIDTH-1:0]                rd_addr_o,
  input  logic [NUM_GROUPS-1:0][DATA_WIDTH-1:0] rd_data_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  we_q;
  logic [2:0]            group_q;
  logic [ADDR_WIDTH-1:0] osc_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rd_sel;

  // Group decode: only indices below NUM_GROUPS have a lane, so an unmapped
  // group matches nothing -- no request pulse and a zero read result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_req_o = '0;
    rd_req_o = '0;
    rd_sel   = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (group_q == 3'(g)) begin
        rd_sel = rd_data_i[g];
        if (state == S_ISSUE) begin
          wr_req_o[g] = we_q;
          rd_req_o[g] = !we_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      group_q  <= '0;
      osc_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of statement order.
      case (state)
        S_IDLE: begin
          if (host_req_i) begin
            we_q    <= host_we_i;
            group_q <= host_addr_i[ADDR_WIDTH+2:ADDR_WIDTH];
            osc_q   <= host_addr_i[ADDR_WIDTH-1:0];
            wdata_q <= host_wdata_i;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_RESP;
            // Sample the RAM only once its service window has elapsed.
            if (!we_q) rdata_q <= rd_sel;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host_ready_o  = (state == S_IDLE);
  assign host_rvalid_o = (state == S_RESP) && !we_q;
  assign host_rdata_o  = rdata_q;
  assign wr_addr_o     = osc_q;
  assign rd_addr_o     = osc_q;
  assign wr_data_o     = wdata_q;

endmodule

// File: tb/tb_doc5503_host_access.sv
// -----------------------------------------------------------------------------
// tb_doc5503_host_access
//
// Directed bench for doc5503_host_access. Three instances share all inputs:
// the main one with WAIT_CYCLES=3 and two more with WAIT_CYCLES=2 and 15 for
// the window-length timing. "Cycle n" is the cycle after the n-th rising edge
// following the cycle in which the request is first presented (cycle 0).
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_doc5503_host_access;

  localparam int NG = 7;
  localparam int AW = 5;
  localparam int DW = 8;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             host_req_i;
  logic             host_we_i;
  logic [AW+2:0]    host_addr_i;
  logic [DW-1:0]    host_wdata_i;
  logic [NG-1:0][DW-1:0] rd_data_i;

  // main instance (WAIT_CYCLES = 3)
  logic             ready, rvalid;
  logic [DW-1:0]    rdata, wr_data;
  logic [NG-1:0]    wr_req, rd_req;
  logic [AW-1:0]    wr_addr, rd_addr;
  // WAIT_CYCLES = 2
  logic             ready2, rvalid2;
  logic [DW-1:0]    rdata2, wr_data2;
  logic [NG-1:0]    wr_req2, rd_req2;
  logic [AW-1:0]    wr_addr2, rd_addr2;
  // WAIT_CYCLES = 15
  logic             ready15, rvalid15;
  logic [DW-1:0]    rdata15, wr_data15;
  logic [NG-1:0]    wr_req15, rd_req15;
  logic [AW-1:0]    wr_addr15, rd_addr15;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  doc5503_host_access #(.NUM_GROUPS(NG), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .host_req_i(host_req_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_ready_o(ready),
    .host_rvalid_o(rvalid), .host_rdata_o(rdata), .wr_req_o(wr_req), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_data_i(rd_data_i));

  doc5503_host_access #(.NUM_GROUPS(NG), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .host_req_i(host_req_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_ready_o(ready2),
    .host_rvalid_o(rvalid2), .host_rdata_o(rdata2), .wr_req_o(wr_req2), .wr_addr_o(wr_addr2),
    .wr_data_o(wr_data2), .rd_req_o(rd_req2), .rd_addr_o(rd_addr2), .rd_data_i(rd_data_i));

  doc5503_host_access #(.NUM_GROUPS(NG), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(15)) dut15 (
    .clk_i(clk_i), .reset_i(reset_i), .host_req_i(host_req_i), .host_we_i(host_we_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_ready_o(ready15),
    .host_rvalid_o(rvalid15), .host_rdata_o(rdata15), .wr_req_o(wr_req15), .wr_addr_o(wr_addr15),
    .wr_data_o(wr_data15), .rd_req_o(rd_req15), .rd_addr_o(rd_addr15), .rd_data_i(rd_data_i));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    host_req_i   = 1'b1;
    host_we_i    = we;
    host_addr_i  = addr;
    host_wdata_i = wdata;
  endtask

  initial begin
    reset_i      = 1'b1;
    host_req_i   = 1'b0;
    host_we_i    = 1'b0;
    host_addr_i  = '0;
    host_wdata_i = '0;
    for (int g = 0; g < NG; g++) rd_data_i[g] = {g[3:0], 4'hF};
    rd_data_i[1] = 8'h3C;

    // ---- reset state ----
    tick();
    tick();
    check("rst_ready",   32'(ready),   32'd1);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rdata",   32'(rdata),   32'd0);
    check("rst_wr_req",  32'(wr_req),  32'd0);
    check("rst_rd_req",  32'(rd_req),  32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    reset_i = 1'b0;

    // ---- mapped write 0xA5 -> 0x45 (group 2, osc 5) ----
    present(1'b1, 8'h45, 8'hA5);
    tick();
    host_req_i = 1'b0;
    check("wr_c1_wr_req",  32'(wr_req),  32'h04);
    check("wr_c1_rd_req",  32'(rd_req),  32'h00);
    check("wr_c1_wr_addr", 32'(wr_addr), 32'd5);
    check("wr_c1_wr_data", 32'(wr_data), 32'hA5);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin
        tick();
        check("wr_wait_wr_req", 32'(wr_req), 32'h00);
        check("wr_wait_rd_req", 32'(rd_req), 32'h00);
      end
      check("wr_ready_low", 32'(ready),  32'd0);
      check("wr_no_rvalid", 32'(rvalid), 32'd0);
      check("wr_hold_data", 32'(wr_data), 32'hA5);
    end
    tick();
    check("wr_c6_ready", 32'(ready), 32'd1);
    check("wr_c6_rdata", 32'(rdata), 32'd0);

    // ---- mapped read 0x23 (group 1, osc 3) ----
    present(1'b0, 8'h23, 8'h00);
    tick();
    host_req_i = 1'b0;
    check("rd_c1_rd_req",  32'(rd_req),  32'h02);
    check("rd_c1_wr_req",  32'(wr_req),  32'h00);
    check("rd_c1_rd_addr", 32'(rd_addr), 32'd3);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("rd_wait_rvalid", 32'(rvalid), 32'd0);
      check("rd_wait_rd_req", 32'(rd_req), 32'h00);
    end
    tick();
    check("rd_c5_rvalid", 32'(rvalid), 32'd1);
    check("rd_c5_rdata",  32'(rdata),  32'h3C);
    check("rd_c5_ready",  32'(ready),  32'd0);
    tick();
    check("rd_c6_rvalid", 32'(rvalid), 32'd0);
    check("rd_c6_ready",  32'(ready),  32'd1);
    tick();
    tick();
    check("rd_c8_rdata",  32'(rdata),  32'h3C);

    // ---- unmapped read 0xE7 ----
    present(1'b0, 8'hE7, 8'h00);
    tick();
    host_req_i = 1'b0;
    check("um_rd_c1_rd_req", 32'(rd_req), 32'h00);
    check("um_rd_c1_wr_req", 32'(wr_req), 32'h00);
    for (int c = 2; c <= 5; c++) tick();
    check("um_rd_c5_rvalid", 32'(rvalid), 32'd1);
    check("um_rd_c5_rdata",  32'(rdata),  32'h00);
    tick();

    // ---- unmapped write 0xE7 ----
    rd_data_i[1] = 8'h3C;
    present(1'b1, 8'hE7, 8'h5A);
    tick();
    host_req_i = 1'b0;
    check("um_wr_c1_wr_req", 32'(wr_req), 32'h00);
    check("um_wr_c1_rd_req", 32'(rd_req), 32'h00);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("um_wr_ready_low", 32'(ready),  32'd0);
      check("um_wr_no_rvalid", 32'(rvalid), 32'd0);
    end
    tick();
    check("um_wr_c6_ready", 32'(ready), 32'd1);

    // ---- back-to-back reads with request held: 0x01 then 0xDF ----
    present(1'b0, 8'h01, 8'h00);
    tick();
    check("b2b_c1_rd_req",  32'(rd_req),  32'h01);
    check("b2b_c1_rd_addr", 32'(rd_addr), 32'd1);
    host_addr_i = 8'h55;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 3) host_addr_i = 8'hDF;
      check("b2b_ready_low", 32'(ready),   32'd0);
      check("b2b_no_req",    32'(rd_req),  32'h00);
      check("b2b_addr_hold", 32'(rd_addr), 32'd1);
    end
    check("b2b_c5_rvalid", 32'(rvalid), 32'd1);
    check("b2b_c5_rdata",  32'(rdata),  32'h0F);
    tick();
    check("b2b_c6_ready",  32'(ready),  32'd1);
    tick();
    host_req_i = 1'b0;
    check("b2b_c7_rd_req",  32'(rd_req),  32'h40);
    check("b2b_c7_rd_addr", 32'(rd_addr), 32'd31);
    for (int c = 8; c <= 11; c++) tick();
    check("b2b_c11_rvalid", 32'(rvalid), 32'd1);
    check("b2b_c11_rdata",  32'(rdata),  32'h6F);
    tick();

    // ---- reset in cycle 3 of a read ----
    present(1'b0, 8'h23, 8'h00);
    tick();
    host_req_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    #1;
    check("mrst_ready",   32'(ready),   32'd1);
    check("mrst_rvalid",  32'(rvalid),  32'd0);
    check("mrst_rdata",   32'(rdata),   32'd0);
    check("mrst_rd_addr", 32'(rd_addr), 32'd0);
    tick();
    reset_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("mrst_no_rvalid", 32'(rvalid), 32'd0);
      check("mrst_ready_hi",  32'(ready),  32'd1);
    end

    // next read after reset (0x45 -> group 2)
    present(1'b0, 8'h45, 8'h00);
    tick();
    host_req_i = 1'b0;
    check("post_c1_rd_req", 32'(rd_req), 32'h04);
    for (int c = 2; c <= 5; c++) tick();
    check("post_c5_rvalid", 32'(rvalid), 32'd1);
    check("post_c5_rdata",  32'(rdata),  32'h2F);

    // let every instance, including WAIT_CYCLES=15, return to idle
    for (int c = 0; c < 20; c++) tick();
    check("idle_ready2",  32'(ready2),  32'd1);
    check("idle_ready15", 32'(ready15), 32'd1);

    // ---- window length: WAIT_CYCLES = 2 and 15, read 0x23 ----
    present(1'b0, 8'h23, 8'h00);
    tick();
    host_req_i = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) tick();
      check("w2_rvalid",  32'(rvalid2),  (c == 4)  ? 32'd1 : 32'd0);
      check("w15_rvalid", 32'(rvalid15), (c == 17) ? 32'd1 : 32'd0);
      if (c == 4)  check("w2_rdata",  32'(rdata2),  32'h3C);
      if (c == 4)  check("w2_c4_ready",  32'(ready2), 32'd0);
      if (c == 5)  check("w2_c5_ready",  32'(ready2), 32'd1);
      if (c == 17) check("w15_rdata", 32'(rdata15), 32'h3C);
      if (c == 17) check("w15_c17_ready", 32'(ready15), 32'd0);
      if (c == 18) check("w15_c18_ready", 32'(ready15), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
